// File: rtl/wb_result_fifo.sv
// wb_result_fifo: captures qualified CPU writeback results into a small
// first-word-fall-through FIFO and hands them to a reader over valid/ready.
// Pushes that arrive while the FIFO is full (and not being popped in the
// same cycle) are dropped, flagged by a sticky overflow bit and counted in
// a saturating drop counter.
module wb_result_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [AW:0]       FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]       COUNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0]       COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]     PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0]     PTR_ONE    = AW'(1);
    localparam logic [DROP_W-1:0] DROP_ZERO  = {DROP_W{1'b0}};
    localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};

    // Storage is deliberately left out of reset; rd_data is meaningless while empty.
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              overflow_r;
    logic [DROP_W-1:0] drop_cnt_r;

    logic full_s;
    logic empty_s;
    logic push_req_s;
    logic pop_s;
    logic push_s;
    logic drop_s;

    // Handshake decode: a pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        full_s     = (count_r == FULL_COUNT);
        empty_s    = (count_r == COUNT_ZERO);
        push_req_s = enable & wb_valid;
        pop_s      = (~empty_s) & rd_ready;
        push_s     = push_req_s & ((~full_s) | pop_s);
        drop_s     = push_req_s & full_s & (~pop_s);
    end

    // Result storage write; no reset so the RAM can map to plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= wb_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset overrides any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Drop tracking: sticky overflow flag and a counter that parks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= DROP_ZERO;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != DROP_MAX) begin
                drop_cnt_r <= drop_cnt_r + DROP_ONE;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    // Output view: everything derives from registered state, none from wb_data directly.
    always_comb begin
        rd_valid = ~empty_s;
        rd_data  = mem_r[rd_ptr_r];
        count    = count_r;
        full     = full_s;
        empty    = empty_s;
        overflow = overflow_r;
        drop_cnt = drop_cnt_r;
    end

endmodule
